// File: rtl/link_monitor_pkg.sv
// Shared types and the granule helper for the multi-port LL/SC reservation tracker.
// Granules are carried at a fixed wide width and compared whole, so no bits are dropped.
package link_pkg;

    localparam int GMAX = 64;

    typedef logic [2:0]      port_idx_t;
    typedef logic [GMAX-1:0] gran_t;

    function automatic gran_t gran(input gran_t a, input int gb);
        return a >> gb;
    endfunction

endpackage

// File: rtl/link_monitor_if.sv
// Per-port decode-side request bundle and the gated memory-side responses.
interface link_monitor_if #(
    parameter int BITS      = 32,
    parameter int NUM_PORTS = 2
);

    logic [NUM_PORTS-1:0]      load_link_;
    logic [NUM_PORTS-1:0]      check_link;
    logic [NUM_PORTS-1:0]      mem_rw_;
    logic [NUM_PORTS*BITS-1:0] addr;
    logic [NUM_PORTS-1:0]      use_mem_rw_;
    logic [NUM_PORTS-1:0]      sc_ok;
    logic [NUM_PORTS-1:0]      link_valid;

    modport master (
        output load_link_, check_link, mem_rw_, addr,
        input  use_mem_rw_, sc_ok, link_valid
    );

    modport slave (
        input  load_link_, check_link, mem_rw_, addr,
        output use_mem_rw_, sc_ok, link_valid
    );

endinterface

// File: rtl/link_monitor_slot.sv
// One port's reservation: valid flag, reserved granule, saturating expiry counter
// and the same-cycle match against the port's current address.
module link_slot
    import link_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int GRAN_BITS    = 2,
    parameter int LINK_TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      ll_s,
    input  logic                      sc_s,
    input  logic                      kill_s,
    input  gran_t                     addr_gran_s,
    output logic                      link_valid_r,
    output logic [BITS-GRAN_BITS-1:0] link_gran_r,
    output logic                      match_s
);

    localparam int GW    = BITS - GRAN_BITS;
    localparam int CNT_W = (LINK_TIMEOUT > 0) ? $clog2(LINK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LINK_TIMEOUT > 0) ? LINK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             expire_s;

    assign expire_s = (LINK_TIMEOUT > 0) && link_valid_r && (cnt_r == CNT_LAST);
    assign match_s  = link_valid_r && (addr_gran_s == gran_t'(link_gran_r));

    // Reservation state: a new LL beats every clear; otherwise age the link while it is held.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            link_valid_r <= 1'b0;
            link_gran_r  <= {GW{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
        end else if (ll_s) begin
            link_valid_r <= 1'b1;
            link_gran_r  <= addr_gran_s[GW-1:0];
            cnt_r        <= {CNT_W{1'b0}};
        end else if (sc_s || kill_s || expire_s) begin
            link_valid_r <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else if (link_valid_r && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/link_monitor.sv
// Multi-port LL/SC tracker: per-port slots plus the cross-port SC arbitration
// and the invalidate fan-out from every effective write.
module link_monitor
    import link_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int NUM_PORTS    = 2,
    parameter int GRAN_BITS    = 2,
    parameter int LINK_TIMEOUT = 0
) (
    input logic           clk,
    input logic           rst_,
    link_monitor_if.slave bus
);

    localparam int GW = BITS - GRAN_BITS;

    gran_t                addr_gran_s [NUM_PORTS];
    logic [GW-1:0]        link_gran_r [NUM_PORTS];
    logic [NUM_PORTS-1:0] link_valid_r;
    logic [NUM_PORTS-1:0] match_s;
    logic [NUM_PORTS-1:0] ll_s;
    logic [NUM_PORTS-1:0] cand_s;
    logic [NUM_PORTS-1:0] lost_s;
    logic [NUM_PORTS-1:0] sc_ok_s;
    logic [NUM_PORTS-1:0] use_mem_rw_s;
    logic [NUM_PORTS-1:0] kill_s;

    assign ll_s   = ~bus.load_link_;
    // An asserted LL on the same port masks the SC entirely.
    assign cand_s = bus.check_link & bus.load_link_ & match_s;

    // Granule of each port's current effective address.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_gran_s[p] = gran(gran_t'(bus.addr[p*BITS +: BITS]), GRAN_BITS);
        end
    end

    // SC arbitration (lowest index wins a shared granule), write gating and invalidate fan-out.
    always_comb begin
        lost_s       = {NUM_PORTS{1'b0}};
        use_mem_rw_s = {NUM_PORTS{1'b1}};
        kill_s       = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                lost_s[p] = lost_s[p] | ((q < p) && cand_s[q] &&
                                         (addr_gran_s[q] == addr_gran_s[p]));
            end
        end
        sc_ok_s = cand_s & ~lost_s;
        for (int p = 0; p < NUM_PORTS; p++) begin
            use_mem_rw_s[p] = bus.check_link[p] ? ~sc_ok_s[p] : bus.mem_rw_[p];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                kill_s[p] = kill_s[p] | ((q != p) && !use_mem_rw_s[q] &&
                                         (addr_gran_s[q] == gran_t'(link_gran_r[p])));
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
        link_slot #(
            .BITS         (BITS),
            .GRAN_BITS    (GRAN_BITS),
            .LINK_TIMEOUT (LINK_TIMEOUT)
        ) u_slot (
            .clk          (clk),
            .rst_         (rst_),
            .ll_s         (ll_s[p]),
            .sc_s         (bus.check_link[p]),
            .kill_s       (kill_s[p]),
            .addr_gran_s  (addr_gran_s[p]),
            .link_valid_r (link_valid_r[p]),
            .link_gran_r  (link_gran_r[p]),
            .match_s      (match_s[p])
        );
    end

    assign bus.sc_ok       = sc_ok_s;
    assign bus.use_mem_rw_ = use_mem_rw_s;
    assign bus.link_valid  = link_valid_r;

endmodule

// File: tb/tb_link_monitor.sv
// Directed-vector bench for link_monitor with a queue-based scoreboard:
// the driver pushes each cycle's hand-computed response, a negedge monitor pops and compares.
module tb_link_monitor;

    logic clk;
    logic rst_;

    link_monitor_if #(.BITS(32), .NUM_PORTS(2)) bus ();

    link_monitor #(
        .BITS         (32),
        .NUM_PORTS    (2),
        .GRAN_BITS    (2),
        .LINK_TIMEOUT (4)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    typedef struct {
        string      nm;
        logic [1:0] sc;
        logic [1:0] use_;
        logic [1:0] lv;
    } exp_t;

    exp_t sb_q [$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the popped expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks += 3;
            if (bus.sc_ok !== e.sc) begin
                errors++;
                $display("FAIL %s sc_ok got %b want %b", e.nm, bus.sc_ok, e.sc);
            end
            if (bus.use_mem_rw_ !== e.use_) begin
                errors++;
                $display("FAIL %s use_mem_rw_ got %b want %b", e.nm, bus.use_mem_rw_, e.use_);
            end
            if (bus.link_valid !== e.lv) begin
                errors++;
                $display("FAIL %s link_valid got %b want %b", e.nm, bus.link_valid, e.lv);
            end
        end
    end

    task automatic step(input logic rst_v, input string nm,
                        input logic [1:0] ll, input logic [1:0] cl, input logic [1:0] mrw,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] e_sc, input logic [1:0] e_use, input logic [1:0] e_lv);
        exp_t x;
        @(posedge clk);
        #1;
        rst_           = rst_v;
        bus.load_link_ = ll;
        bus.check_link = cl;
        bus.mem_rw_    = mrw;
        bus.addr       = {a1, a0};
        x.nm   = nm;
        x.sc   = e_sc;
        x.use_ = e_use;
        x.lv   = e_lv;
        sb_q.push_back(x);
    endtask

    initial begin
        rst_           = 1'b0;
        bus.load_link_ = 2'b11;
        bus.check_link = 2'b00;
        bus.mem_rw_    = 2'b11;
        bus.addr       = 64'h0;

        // reset: outputs pass mem_rw_ through, no SC can succeed
        step(1'b0, "rst_pass",   2'b11, 2'b00, 2'b10, 32'h40,  32'h44,  2'b00, 2'b10, 2'b00);
        step(1'b0, "rst_sc",     2'b11, 2'b01, 2'b10, 32'h40,  32'h44,  2'b00, 2'b11, 2'b00);
        // LL then SC next cycle succeeds
        step(1'b1, "ll0_40",     2'b10, 2'b00, 2'b11, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        step(1'b1, "sc0_40",     2'b11, 2'b01, 2'b10, 32'h40,  32'h0,   2'b01, 2'b10, 2'b01);
        step(1'b1, "after_sc0",  2'b11, 2'b00, 2'b11, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        // store by port 1 into the same granule kills port 0's link
        step(1'b1, "ll0_again",  2'b10, 2'b00, 2'b11, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        step(1'b1, "st1_41",     2'b11, 2'b00, 2'b01, 32'h40,  32'h41,  2'b00, 2'b01, 2'b01);
        step(1'b1, "sc0_killed", 2'b11, 2'b01, 2'b10, 32'h40,  32'h41,  2'b00, 2'b11, 2'b00);
        // both SC the same granule: port 0 wins
        step(1'b1, "ll_both_80", 2'b00, 2'b00, 2'b11, 32'h80,  32'h80,  2'b00, 2'b11, 2'b00);
        step(1'b1, "sc_both_80", 2'b11, 2'b11, 2'b00, 32'h80,  32'h80,  2'b01, 2'b10, 2'b11);
        step(1'b1, "after_both", 2'b11, 2'b00, 2'b11, 32'h80,  32'h80,  2'b00, 2'b11, 2'b00);
        // expiry: four idle cycles lose the link
        step(1'b1, "ll1_100",    2'b01, 2'b00, 2'b11, 32'h0,   32'h100, 2'b00, 2'b11, 2'b00);
        for (int i = 0; i < 4; i++)
            step(1'b1, "idle_exp",   2'b11, 2'b00, 2'b11, 32'h0, 32'h100, 2'b00, 2'b11, 2'b10);
        step(1'b1, "sc1_expired",2'b11, 2'b10, 2'b01, 32'h0,   32'h100, 2'b00, 2'b11, 2'b00);
        // three idle cycles keep it
        step(1'b1, "ll1_100b",   2'b01, 2'b00, 2'b11, 32'h0,   32'h100, 2'b00, 2'b11, 2'b00);
        for (int i = 0; i < 3; i++)
            step(1'b1, "idle_keep",  2'b11, 2'b00, 2'b11, 32'h0, 32'h100, 2'b00, 2'b11, 2'b10);
        step(1'b1, "sc1_in_time",2'b11, 2'b10, 2'b01, 32'h0,   32'h100, 2'b10, 2'b01, 2'b10);
        step(1'b1, "after_sc1",  2'b11, 2'b00, 2'b11, 32'h0,   32'h100, 2'b00, 2'b11, 2'b00);
        // LL and SC together: LL wins, no write
        step(1'b1, "ll_sc_same", 2'b10, 2'b01, 2'b10, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        step(1'b1, "after_llsc", 2'b11, 2'b00, 2'b11, 32'h40,  32'h0,   2'b00, 2'b11, 2'b01);
        // reset pulse drops the link, later SC fails
        step(1'b0, "rst_drop",   2'b11, 2'b00, 2'b11, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        step(1'b1, "sc0_post_rst",2'b11,2'b01, 2'b10, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        // SC to a different granule fails
        step(1'b1, "ll0_40c",    2'b10, 2'b00, 2'b11, 32'h40,  32'h0,   2'b00, 2'b11, 2'b00);
        step(1'b1, "sc0_44",     2'b11, 2'b01, 2'b10, 32'h44,  32'h0,   2'b00, 2'b11, 2'b01);
        step(1'b1, "after_44",   2'b11, 2'b00, 2'b11, 32'h44,  32'h0,   2'b00, 2'b11, 2'b00);
        // distinct granules: both SCs succeed
        step(1'b1, "ll_split",   2'b00, 2'b00, 2'b11, 32'h40,  32'h80,  2'b00, 2'b11, 2'b00);
        step(1'b1, "sc_split",   2'b11, 2'b11, 2'b00, 32'h40,  32'h80,  2'b11, 2'b00, 2'b11);
        step(1'b1, "after_split",2'b11, 2'b00, 2'b11, 32'h40,  32'h80,  2'b00, 2'b11, 2'b00);
        // LL beats a same-cycle store by the other port
        step(1'b1, "ll0_st1",    2'b10, 2'b00, 2'b01, 32'h40,  32'h40,  2'b00, 2'b01, 2'b00);
        step(1'b1, "sc0_ll_won", 2'b11, 2'b01, 2'b10, 32'h40,  32'h40,  2'b01, 2'b10, 2'b01);
        step(1'b1, "final_idle", 2'b11, 2'b00, 2'b11, 32'h40,  32'h40,  2'b00, 2'b11, 2'b00);

        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending got %0d want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
